// File: rtl/fp_div_if.sv
// Issue-side valid/ready bundle for the iterative floating-point divider.
interface fp_div_if #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned frac_width = 23
);
  localparam int unsigned word_w = exp_width + frac_width + 1;

  logic              in_valid;
  logic              in_ready;
  logic [word_w-1:0] op1;
  logic [word_w-1:0] op2;
  logic [1:0]        round_mode;
  logic              out_valid;
  logic              out_ready;
  logic [word_w-1:0] result;
  logic [4:0]        exception;

  modport master (
    output in_valid, op1, op2, round_mode, out_ready,
    input  in_ready, out_valid, result, exception
  );

  modport slave (
    input  in_valid, op1, op2, round_mode, out_ready,
    output in_ready, out_valid, result, exception
  );
endinterface

// File: rtl/fp_iter_div.sv
// Multi-cycle IEEE-754 divider: one restoring quotient bit per cycle, then round.
// Special operands resolve without iterating; denormals are treated as zero.
module fp_iter_div #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned frac_width = 23
) (
  input logic     clk,
  input logic     rst,
  fp_div_if.slave bus
);
  localparam int unsigned word_w  = exp_width + frac_width + 1;
  localparam int unsigned man_w   = frac_width + 1;
  localparam int unsigned rem_w   = frac_width + 2;
  localparam int unsigned iter_n  = frac_width + 4;
  localparam int unsigned cnt_w   = $clog2(iter_n + 1);
  localparam int unsigned se_w    = exp_width + 2;
  localparam int unsigned frw     = frac_width + 1;
  localparam int unsigned bias    = (1 << (exp_width - 1)) - 1;
  localparam int unsigned exp_max = (1 << exp_width) - 1;

  localparam int unsigned fp_invalid   = 4;
  localparam int unsigned fp_divbyzero = 3;
  localparam int unsigned fp_overflow  = 2;
  localparam int unsigned fp_underflow = 1;
  localparam int unsigned fp_inexact   = 0;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [exp_width-1:0] e1_q, e1_d, e2_q, e2_d;
  logic [1:0]         mode_q, mode_d;
  logic [man_w-1:0]   dvs_q, dvs_d;
  logic [rem_w-1:0]   rem_q, rem_d;
  logic [iter_n-1:0]  quo_q, quo_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [word_w-1:0]  result_q, result_d;
  logic [4:0]         exc_q, exc_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready;

  // Operand fields and classification
  logic                  s1, s2, sq;
  logic [exp_width-1:0]  x1, x2;
  logic [frac_width-1:0] f1, f2;
  logic nan1, nan2, inf1, inf2, zero1, zero2;

  assign {s1, x1, f1} = bus.op1;
  assign {s2, x2, f2} = bus.op2;
  assign sq    = s1 ^ s2;
  assign nan1  = (&x1) && (|f1);
  assign nan2  = (&x2) && (|f2);
  assign inf1  = (&x1) && !(|f1);
  assign inf2  = (&x2) && !(|f2);
  assign zero1 = (x1 == '0);
  assign zero2 = (x2 == '0);

  logic              spec_hit;
  logic [word_w-1:0] spec_res;
  logic [4:0]        spec_exc;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_exc = '0;
    if (nan1) begin
      spec_res = bus.op1;
    end else if (nan2) begin
      spec_res = bus.op2;
    end else if ((zero1 && zero2) || (inf1 && inf2)) begin
      spec_res = {1'b1, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};
      spec_exc[fp_invalid] = 1'b1;
    end else if (inf1) begin
      spec_res = {sq, {exp_width{1'b1}}, {frac_width{1'b0}}};
    end else if (zero2) begin
      spec_res = {sq, {exp_width{1'b1}}, {frac_width{1'b0}}};
      spec_exc[fp_divbyzero] = 1'b1;
    end else if (inf2 || zero1) begin
      spec_res = {sq, {(word_w-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Restoring division step
  logic [rem_w-1:0] trial, rem_sel;
  logic             ge;
  assign trial   = rem_q - {1'b0, dvs_q};
  assign ge      = rem_q >= {1'b0, dvs_q};
  assign rem_sel = ge ? trial : rem_q;

  // Normalize, round and compute the biased exponent
  logic                  adj, guard, rnd, sticky, inc, ovf, unf;
  logic [iter_n-2:0]     qn;
  logic [frac_width-1:0] frac_t;
  logic [frac_width:0]   frac_r;
  logic [se_w-1:0]       e_raw;

  assign adj    = ~quo_q[iter_n-1];
  assign qn     = adj ? {quo_q[iter_n-3:0], 1'b0} : quo_q[iter_n-2:0];
  assign frac_t = qn[iter_n-2:3];
  assign guard  = qn[2];
  assign rnd    = qn[1];
  assign sticky = qn[0] | (|rem_q);

  always_comb begin
    inc = 1'b0;
    case (mode_q)
      2'd0: inc = guard & (rnd | sticky | frac_t[0]);
      2'd1: inc = 1'b0;
      2'd2: inc = sign_q & (guard | rnd | sticky);
      2'd3: inc = ~sign_q & (guard | rnd | sticky);
    endcase
  end

  assign frac_r = {1'b0, frac_t} + frw'(inc);
  assign e_raw  = se_w'(e1_q) - se_w'(e2_q) + se_w'(bias) - se_w'(adj) + se_w'(frac_r[frac_width]);
  assign ovf    = $signed(e_raw) >= $signed(se_w'(exp_max));
  assign unf    = $signed(e_raw) < $signed(se_w'(1));

  assign in_ready      = (state_q == IDLE) && !rst;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.exception = exc_q;

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    mode_d      = mode_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    exc_d       = exc_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          mode_d = bus.round_mode;
          sign_d = sq;
          e1_d   = x1;
          e2_d   = x2;
          dvs_d  = {1'b1, f2};
          rem_d  = {2'b01, f1};
          quo_d  = '0;
          cnt_d  = '0;
          if (spec_hit) begin
            result_d = spec_res;
            exc_d    = spec_exc;
            state_d  = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        quo_d = {quo_q[iter_n-2:0], ge};
        rem_d = rem_sel << 1;
        cnt_d = cnt_q + cnt_w'(1);
        if (cnt_q == cnt_w'(iter_n - 1)) state_d = ROUND;
      end
      ROUND: begin
        exc_d = '0;
        if (ovf) begin
          result_d = {sign_q, {exp_width{1'b1}}, {frac_width{1'b0}}};
          exc_d[fp_overflow] = 1'b1;
          exc_d[fp_inexact]  = 1'b1;
        end else if (unf) begin
          result_d = {sign_q, {(word_w-1){1'b0}}};
          exc_d[fp_underflow] = 1'b1;
          exc_d[fp_inexact]   = 1'b1;
        end else begin
          result_d = {sign_q, e_raw[exp_width-1:0], frac_r[frac_width-1:0]};
          exc_d[fp_inexact] = guard | rnd | sticky;
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // Special results enter here with out_valid still low; it rises on the next edge.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      e1_q        <= '0;
      e2_q        <= '0;
      mode_q      <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      exc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sign_q      <= sign_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      mode_q      <= mode_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_fp_iter_div.sv
// Directed bench for fp_iter_div: hand-computed binary32 quotients, specials,
// latency, backpressure and mid-operation reset.
module tb_fp_iter_div;
  localparam int unsigned exp_width  = 8;
  localparam int unsigned frac_width = 23;
  localparam logic [4:0] nv = 5'h10, dz = 5'h08, of = 5'h04, uf = 5'h02, nx = 5'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fp_div_if #(.exp_width(exp_width), .frac_width(frac_width)) bus ();

  fp_iter_div #(.exp_width(exp_width), .frac_width(frac_width)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait (bounded) for out_valid, leaving it pending.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input int exp_lat, input string tag);
    int lat;
    bit busy_ready;
    bus.op1 = a;
    bus.op2 = b;
    bus.round_mode = m;
    bus.in_valid = 1'b1;
    check({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    busy_ready = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      step();
      lat++;
      if (bus.in_ready) busy_ready = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " in_ready_busy"}, 32'(busy_ready), 32'd0);
  endtask

  task automatic result_chk(input logic [31:0] r, input logic [4:0] e, input string tag);
    check({tag, " result"}, bus.result, r);
    check({tag, " exception"}, 32'(bus.exception), 32'(e));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                     input int exp_lat, input logic [31:0] r, input logic [4:0] e,
                     input string tag);
    issue(a, b, m, exp_lat, tag);
    result_chk(r, e, tag);
    handshake(tag);
  endtask

  initial begin
    bit ov_seen;
    bus.in_valid   = 1'b0;
    bus.op1        = '0;
    bus.op2        = '0;
    bus.round_mode = 2'd0;
    bus.out_ready  = 1'b0;

    repeat (3) step();
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst result", bus.result, 32'h0);
    check("rst exception", 32'(bus.exception), 32'd0);
    rst = 1'b0;
    #1;
    check("release in_ready", 32'(bus.in_ready), 32'd1);

    run(32'h40C00000, 32'h40000000, 2'd0, 28, 32'h40400000, 5'h00, "div6_2");
    run(32'h3F800000, 32'h40400000, 2'd0, 28, 32'h3EAAAAAB, nx, "third_rne");
    run(32'h3F800000, 32'h40400000, 2'd1, 28, 32'h3EAAAAAA, nx, "third_rtz");
    run(32'h3F800000, 32'h40400000, 2'd3, 28, 32'h3EAAAAAB, nx, "third_rup");
    run(32'hBF800000, 32'h40400000, 2'd2, 28, 32'hBEAAAAAB, nx, "third_rdn");

    run(32'h3F800000, 32'h00000000, 2'd0, 1, 32'h7F800000, dz, "one_by_zero");
    run(32'h00000000, 32'h00000000, 2'd0, 1, 32'hFFC00000, nv, "zero_by_zero");
    run(32'h7FC00001, 32'h3F800000, 2'd0, 1, 32'h7FC00001, 5'h00, "nan_op1");
    run(32'hFF800000, 32'h40000000, 2'd0, 1, 32'hFF800000, 5'h00, "inf_by_two");
    run(32'h40000000, 32'h7F800000, 2'd0, 1, 32'h00000000, 5'h00, "two_by_inf");
    run(32'h00000000, 32'hC0000000, 2'd0, 1, 32'h80000000, 5'h00, "zero_by_neg");

    run(32'h7F000000, 32'h3E800000, 2'd0, 28, 32'h7F800000, of | nx, "overflow");
    run(32'h00800000, 32'h40800000, 2'd0, 28, 32'h00000000, uf | nx, "underflow");

    // Backpressure: outputs frozen and new requests ignored while stalled.
    issue(32'h40C00000, 32'h40000000, 2'd0, 28, "bp");
    for (int i = 0; i < 5; i++) begin
      bus.op1 = 32'h3F800000;
      bus.op2 = 32'h00000000;
      bus.in_valid = 1'b1;
      step();
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      result_chk(32'h40400000, 5'h00, "bp");
    end
    bus.in_valid = 1'b0;
    handshake("bp");
    repeat (3) step();
    check("bp no_ghost", 32'(bus.out_valid), 32'd0);

    // Reset during iteration 10 abandons the operation.
    bus.op1 = 32'h40C00000;
    bus.op2 = 32'h40000000;
    bus.round_mode = 2'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("mid_rst in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst in_ready_held", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst release", 32'(bus.in_ready), 32'd1);
    ov_seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("mid_rst no_result", 32'(ov_seen), 32'd0);
    run(32'h3F800000, 32'h40400000, 2'd0, 28, 32'h3EAAAAAB, nx, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_iter_div.md
# fp_iter_div

Multi-cycle IEEE-754 floating-point divider (op1 / op2), the inverse-direction partner of the combinational floating-point multiplier in the FPU library. It computes one quotient bit per cycle with restoring division and rounds through the shared FloatingPointRound block. Special cases resolve in one cycle. The block connects to the FPU issue logic through valid/ready handshakes on both input and output.

## Interface
- exp_width, 8, exponent field width
- frac_width, 23, stored fraction width (N = frac_width+4 quotient iterations)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block idle and able to accept
- op1  in  exp_width+frac_width+1  dividend
- op2  in  exp_width+frac_width+1  divisor
- round_mode  in  2  0 RNE, 1 RTZ, 2 RDN, 3 RUP
- out_valid  out  1  result/exception valid
- out_ready  in  1  consumer accepts result
- result  out  exp_width+frac_width+1  quotient
- exception  out  5  flags at `FP_INVALID`, `FP_DIVBYZERO`, `FP_OVERFLOW`, `FP_UNDERFLOW`, `FP_INEXACT` (bit positions from FloatingPointConsts.svh)

## Operation
- States: IDLE, DIV, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture the operands and round_mode, then classify:
  - op1 NaN → result=op1; else op2 NaN → result=op2.
  - 0/0 or inf/inf → result={1,all-ones exp,1,0…}, set INVALID.
  - finite nonzero / 0 → ±inf, set DIVBYZERO.
  - inf / finite → ±inf. finite / inf → ±0. 0 / nonzero → ±0.
  - Each special case goes to DONE.
  - Otherwise load mantissas {1,frac}, set remainder=dividend mantissa, and go to DIV.
- Denormal operands (exp==0, frac!=0) are treated as signed zero (DAZ); no flag is raised.
- Sign = op1_sign ^ op2_sign in all non-NaN cases.
- DIV: N iterations. Each cycle: trial = rem - divisor. If non-negative, q bit = 1 and rem = trial<<1; else q bit = 0 and rem <<= 1. After N cycles, q holds 1 integer bit and N-1 fraction bits. Then go to ROUND.
- ROUND:
  - Normalize: if q MSB = 0, shift left 1 and set adj = 1; else adj = 0.
  - Drive FloatingPointRound with in_frac = {frac, guard, round, sticky}. Sticky = OR of the remaining low q bits OR (rem != 0).
  - Biased exponent in exp_width+2-bit signed arithmetic: e = e1 - e2 + bias - adj + round_carry.
  - e ≥ all-ones → ±inf, set OVERFLOW and INEXACT.
  - e ≤ 0 → ±0, set UNDERFLOW and INEXACT.
  - Otherwise result = {sign, e, round_frac}. INEXACT = guard|round|sticky.
  - Go to DONE.
- DONE: out_valid=1. result and exception are held stable until out_valid&&out_ready, then return to IDLE.
- in_ready=0 in DIV, ROUND and DONE. No accept can occur in the same cycle as the DONE handshake.

## Timing
- Reset values: state IDLE, out_valid=0, result=0, exception=0. in_ready=0 while rst=1 and 1 in the first cycle after release.
- Reset asserted in any state aborts the operation on that edge. No result is produced for the aborted operation.
- Normal latency: out_valid rises N+1 edges after the accepting edge (28 for binary32).
- Special-case latency: out_valid rises 1 edge after the accepting edge.
- Throughput: one operation per (latency + 1 handshake cycle) minimum.
- Inputs are ignored outside IDLE. round_mode is sampled only at accept.
- out_ready may be held low indefinitely; outputs must not change while stalled.

## Test plan
- 0x40C00000 / 0x40000000, RNE → 0x40400000, exception 0. out_valid exactly 28 edges after accept; in_ready low throughout.
- 0x3F800000 / 0x40400000:
  - RNE → 0x3EAAAAAB, INEXACT.
  - RTZ → 0x3EAAAAAA, INEXACT.
  - RUP → 0x3EAAAAAB.
  - RDN with op1 = 0xBF800000 → 0xBEAAAAAB.
- Special cases, each with out_valid 1 edge after accept:
  - 0x3F800000 / 0x00000000 → 0x7F800000, DIVBYZERO.
  - 0x00000000 / 0x00000000 → 0xFFC00000, INVALID.
  - 0x7FC00001 / 0x3F800000 → 0x7FC00001.
- Overflow and underflow:
  - 0x7F000000 / 0x3E800000 → 0x7F800000, OVERFLOW|INEXACT.
  - 0x00800000 / 0x40800000 → 0x00000000, UNDERFLOW|INEXACT.
- Backpressure: hold out_ready low for 5 cycles after out_valid. result and exception stay stable, in_valid pulses are ignored, and in_ready rises the edge after the handshake.
- Reset at iteration 10 of DIV: out_valid stays 0, in_ready=1 the cycle after release. A new operation completes correctly with the normal 28-edge latency.
